regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (RegWrite/WriteReg/WriteData) between two write-back requesters: A, the single-cycle ALU path, and B, the multi-cycle load/multiply path. Arbitration is round-robin over valid/ready handshakes. The block also holds a pending-write scoreboard, so the issue logic can stall on source registers that still have a write outstanding. It sits between the execute/memory stages and RegisterFile.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W.
DATA_W, 32, write data width.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
startin  in  1  synchronous, active-high reset.
a_valid  in  1  requester A has a write-back.
a_ready  out  1  A granted this cycle; combinational.
a_reg  in  ADDR_W  A destination register.
a_data  in  DATA_W  A write data.
b_valid  in  1  requester B has a write-back.
b_ready  out  1  B granted this cycle; combinational.
b_reg  in  ADDR_W  B destination register.
b_data  in  DATA_W  B write data.
claim_valid  in  1  issue stage reserves a destination register.
claim_reg  in  ADDR_W  register being reserved.
chk1_reg  in  ADDR_W  source register 1 to check.
chk2_reg  in  ADDR_W  source register 2 to check.
chk1_busy  out  1  chk1_reg has a pending write; combinational.
chk2_busy  out  1  chk2_reg has a pending write; combinational.
RegWrite  out  1  write enable to RegisterFile; registered.
WriteReg  out  ADDR_W  write index to RegisterFile; registered.
WriteData  out  DATA_W  write data to RegisterFile; registered.
last_grant  out  1  0 = A granted last, 1 = B granted last; registered.

Behaviour:
- Reset (startin=1 at a posedge):
  - RegWrite=0, WriteReg=0, WriteData=0.
  - All busy bits cleared.
  - last_grant=1, so A has priority on the first contention.
  - While startin=1, a_ready=b_ready=0.
- Arbitration (combinational, startin=0):
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the requester not named by last_grant.
  - Neither valid -> no grant.
  - At most one ready is high in any cycle.
- Handshake: a transfer occurs at a posedge where valid && ready. Requesters hold reg/data stable while valid && !ready.
- Output stage, latency 1:
  - On a transfer to a nonzero register: RegWrite<=1, WriteReg<=reg, WriteData<=data.
  - RegisterFile commits the write on the following posedge.
  - With no transfer: RegWrite<=0, and WriteReg/WriteData hold their previous values.
  - last_grant updates only on a transfer.
  - Sustained throughput is one write per cycle.
- Register 0:
  - A transfer to reg 0 is accepted and updates last_grant, but RegWrite<=0.
  - A claim of reg 0 is ignored.
  - chkN_busy is always 0 for reg 0.
- Scoreboard:
  - busy[claim_reg] is set at the posedge with claim_valid=1.
  - busy[reg] is cleared at the posedge of a transfer to reg.
  - Claim and transfer to the same reg in the same cycle: set wins.
  - Claim and transfer to different regs: both take effect.
  - A transfer to a non-busy register is legal and leaves its bit clear.
- Busy check: chkN_busy = busy[chkN_reg], from registered state. A register retired this cycle reads busy=1 until the next edge; RegisterFile's write-then-read timing makes that conservative stall correct.
- Reset mid-operation: startin overrides every transfer and claim on that edge. A pending output write is squashed (RegWrite=0 after the edge).

Test Plan:
1. Reset: startin=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, RegWrite=0, chk1_busy=0 for any reg.
2. Single write: A writes reg 1 = 0xAAAA_AAAA -> a_ready=1; next cycle RegWrite=1, WriteReg=1, WriteData=0xAAAA_AAAA; the cycle after, RegWrite=0.
3. Contention: A (reg 2, 0x5555_5555) and B (reg 3, 0x1234_5678) both valid for 2 cycles:
   - cycle 1 grants A, cycle 2 grants B;
   - output sequence reg 2 then reg 3, back to back.
4. Sustained contention: both valid with new data each cycle for 6 cycles -> grants strictly alternate A,B,A,B,A,B.
5. Scoreboard: claim reg 5; check with chk1_reg=5 -> chk1_busy=1 until the posedge of B's transfer to reg 5, then 0. In a separate run, claim reg 5 on the same edge as the transfer -> chk1_busy stays 1.
6. Zero register: A writes reg 0 = 0xFFFF_FFFF -> handshake completes and last_grant=0, RegWrite stays 0. Claim of reg 0 with chk2_reg=0 -> chk2_busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Bundles every bus-level signal of the register-file write-back arbiter:
//   - requester A (single-cycle ALU path):      a_valid/a_ready/a_reg/a_data
//   - requester B (multi-cycle load/mul path):  b_valid/b_ready/b_reg/b_data
//   - scoreboard reservation from issue:        claim_valid/claim_reg
//   - scoreboard lookup for issue:              chk1_reg/chk2_reg -> chk1_busy/chk2_busy
//   - RegisterFile write port:                  RegWrite/WriteReg/WriteData
//   - arbitration history:                      last_grant
//
// Modports:
//   slave  - the arbiter itself.
//   master - the surrounding pipeline (requesters, issue, RegisterFile).
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  // Requester A
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_reg;
  logic [DATA_W-1:0] a_data;

  // Requester B
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_reg;
  logic [DATA_W-1:0] b_data;

  // Scoreboard reservation and lookup
  logic              claim_valid;
  logic [ADDR_W-1:0] claim_reg;
  logic [ADDR_W-1:0] chk1_reg;
  logic [ADDR_W-1:0] chk2_reg;
  logic              chk1_busy;
  logic              chk2_busy;

  // RegisterFile write port
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;

  // Which requester won the most recent transfer (0 = A, 1 = B)
  logic              last_grant;

  modport slave (
    input  a_valid, a_reg, a_data,
    output a_ready,
    input  b_valid, b_reg, b_data,
    output b_ready,
    input  claim_valid, claim_reg, chk1_reg, chk2_reg,
    output chk1_busy, chk2_busy,
    output RegWrite, WriteReg, WriteData, last_grant
  );

  modport master (
    output a_valid, a_reg, a_data,
    input  a_ready,
    output b_valid, b_reg, b_data,
    input  b_ready,
    output claim_valid, claim_reg, chk1_reg, chk2_reg,
    input  chk1_busy, chk2_busy,
    input  RegWrite, WriteReg, WriteData, last_grant
  );

endinterface : regfile_wb_arbiter_if

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single RegisterFile write port between two write-back
// requesters (A = ALU path, B = load/multiply path) with round-robin
// arbitration over valid/ready handshakes, and keeps a pending-write
// scoreboard so issue can stall on sources that still await a write.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge.
//   startin  - synchronous active-high reset.
//   bus      - regfile_wb_arbiter_if.slave:
//                a_*/b_*        requester handshakes (ready is combinational)
//                claim_*        destination reservation from issue
//                chk*_reg/busy  source lookups (combinational from state)
//                RegWrite/WriteReg/WriteData  registered write port
//                last_grant     registered, 0 = A won last, 1 = B won last
//
// Timing: a transfer at edge N appears on the write port after edge N and
// RegisterFile commits it at edge N+1. One write per cycle is sustained.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 startin,
  regfile_wb_arbiter_if.slave  bus
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                r_reg_write;
  logic [ADDR_W-1:0]   r_write_reg;
  logic [DATA_W-1:0]   r_write_data;
  logic                r_last_grant;
  logic [NUM_REGS-1:0] r_busy;

  // -------------------------------------------------------------------------
  // Combinational arbitration
  // -------------------------------------------------------------------------
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_xfer_reg;
  logic [DATA_W-1:0]   w_xfer_data;
  logic [NUM_REGS-1:0] w_busy_next;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block leaves it unassigned (no latch).
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!startin) begin
      if (bus.a_valid && bus.b_valid) begin
        // Contention: the requester that did not win last time goes now.
        w_grant_a = r_last_grant;
        w_grant_b = !r_last_grant;
      end else begin
        w_grant_a = bus.a_valid;
        w_grant_b = bus.b_valid;
      end
    end
  end

  assign w_xfer      = w_grant_a || w_grant_b;
  assign w_xfer_reg  = w_grant_a ? bus.a_reg  : bus.b_reg;
  assign w_xfer_data = w_grant_a ? bus.a_data : bus.b_data;

  assign bus.a_ready = w_grant_a;
  assign bus.b_ready = w_grant_b;

  // -------------------------------------------------------------------------
  // Scoreboard next state: retire first, then reserve, so a claim and a
  // retirement of the same register on one edge leaves the bit set (the
  // newer instruction still owns it). Register 0 never becomes busy.
  // -------------------------------------------------------------------------
  always_comb begin
    w_busy_next = r_busy;
    if (w_xfer) begin
      w_busy_next[w_xfer_reg] = 1'b0;
    end
    if (bus.claim_valid) begin
      w_busy_next[bus.claim_reg] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Lookups read registered state only. A register retiring this cycle
  // still reads busy; RegisterFile's write-then-read timing makes that
  // one-cycle conservative stall harmless.
  assign bus.chk1_busy = r_busy[bus.chk1_reg];
  assign bus.chk2_busy = r_busy[bus.chk2_reg];

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (startin) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so clearing it
      // in reset is legal and required: stale busy bits would deadlock issue.
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_last_grant <= 1'b1;
      r_busy       <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_xfer) begin
        r_last_grant <= w_grant_b;
        // A write to register 0 completes the handshake but is dropped;
        // index/data hold so the write port does not toggle needlessly.
        r_reg_write  <= (w_xfer_reg != '0);
        if (w_xfer_reg != '0) begin
          r_write_reg  <= w_xfer_reg;
          r_write_data <= w_xfer_data;
        end
      end else begin
        r_reg_write <= 1'b0;
      end
    end
  end

  assign bus.RegWrite   = r_reg_write;
  assign bus.WriteReg   = r_write_reg;
  assign bus.WriteData  = r_write_data;
  assign bus.last_grant = r_last_grant;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed vector table (hand-derived expectations) followed by a randomized
// run checked against a behavioural model built from the arbitration and
// scoreboard rules.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic clk = 1'b0;
  logic startin;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk    (clk),
    .startin(startin),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector record: one clock cycle of stimulus, the combinational outputs
  // expected before the edge, and the registered outputs expected after it.
  // -------------------------------------------------------------------------
  typedef struct {
    logic              rst;
    logic              av;
    logic [ADDR_W-1:0] areg;
    logic [DATA_W-1:0] adata;
    logic              bv;
    logic [ADDR_W-1:0] breg;
    logic [DATA_W-1:0] bdata;
    logic              cv;
    logic [ADDR_W-1:0] creg;
    logic [ADDR_W-1:0] c1;
    logic [ADDR_W-1:0] c2;
    logic              e_ar;
    logic              e_br;
    logic              e_c1b;
    logic              e_c2b;
    logic              e_we;
    logic [ADDR_W-1:0] e_wreg;
    logic [DATA_W-1:0] e_wdata;
    logic              e_lg;
  } vec_t;

  function automatic vec_t mk(
    input int rst, input int av, input int areg, input logic [DATA_W-1:0] adata,
    input int bv, input int breg, input logic [DATA_W-1:0] bdata,
    input int cv, input int creg, input int c1, input int c2,
    input int ar, input int br, input int c1b, input int c2b,
    input int we, input int wreg, input logic [DATA_W-1:0] wdata, input int lg);
    vec_t v;
    v.rst   = rst[0];  v.av    = av[0];  v.areg  = areg[ADDR_W-1:0]; v.adata = adata;
    v.bv    = bv[0];   v.breg  = breg[ADDR_W-1:0]; v.bdata = bdata;
    v.cv    = cv[0];   v.creg  = creg[ADDR_W-1:0];
    v.c1    = c1[ADDR_W-1:0];  v.c2 = c2[ADDR_W-1:0];
    v.e_ar  = ar[0];   v.e_br  = br[0];  v.e_c1b = c1b[0]; v.e_c2b = c2b[0];
    v.e_we  = we[0];   v.e_wreg = wreg[ADDR_W-1:0]; v.e_wdata = wdata; v.e_lg = lg[0];
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Behavioural model: which requester wins, which registers await a write,
  // and what the write port shows after each edge.
  // -------------------------------------------------------------------------
  bit                m_busy [NUM_REGS];
  bit                m_last;            // 1 = B won most recently
  bit                m_we;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;

  // 0 = nobody, 1 = A, 2 = B
  function automatic int m_winner();
    if (startin) return 0;
    if (bus.a_valid && bus.b_valid) return m_last ? 1 : 2;
    if (bus.a_valid) return 1;
    if (bus.b_valid) return 2;
    return 0;
  endfunction

  task automatic m_edge(input int w);
    int r;
    if (startin) begin
      m_we = 0; m_wreg = '0; m_wdata = '0; m_last = 1;
      foreach (m_busy[i]) m_busy[i] = 0;
      return;
    end
    if (w != 0) begin
      r      = (w == 1) ? int'(bus.a_reg) : int'(bus.b_reg);
      m_last = (w == 2);
      m_we   = (r != 0);
      if (r != 0) begin
        m_wreg  = (w == 1) ? bus.a_reg  : bus.b_reg;
        m_wdata = (w == 1) ? bus.a_data : bus.b_data;
      end
      m_busy[r] = 0;
    end else begin
      m_we = 0;
    end
    if (bus.claim_valid && bus.claim_reg != 0) m_busy[bus.claim_reg] = 1;
  endtask

  task automatic drive(input vec_t v);
    startin         = v.rst;
    bus.a_valid     = v.av;  bus.a_reg = v.areg; bus.a_data = v.adata;
    bus.b_valid     = v.bv;  bus.b_reg = v.breg; bus.b_data = v.bdata;
    bus.claim_valid = v.cv;  bus.claim_reg = v.creg;
    bus.chk1_reg    = v.c1;  bus.chk2_reg  = v.c2;
  endtask

  // One cycle with inputs already driven just after an edge: compare the
  // combinational outputs mid-cycle, take the edge, compare the registered
  // outputs 1 time unit later. Expectations come from the vector or model.
  task automatic do_cycle(input string tag, input bit use_model, input vec_t v, output int w);
    vec_t e;
    e = v;
    #1;
    w = m_winner();
    if (use_model) begin
      e.e_ar  = (w == 1);
      e.e_br  = (w == 2);
      e.e_c1b = m_busy[bus.chk1_reg];
      e.e_c2b = m_busy[bus.chk2_reg];
    end
    check({tag, " a_ready"},   64'(bus.a_ready),   64'(e.e_ar));
    check({tag, " b_ready"},   64'(bus.b_ready),   64'(e.e_br));
    check({tag, " chk1_busy"}, 64'(bus.chk1_busy), 64'(e.e_c1b));
    check({tag, " chk2_busy"}, 64'(bus.chk2_busy), 64'(e.e_c2b));
    @(posedge clk);
    m_edge(w);
    #1;
    if (use_model) begin
      e.e_we = m_we; e.e_wreg = m_wreg; e.e_wdata = m_wdata; e.e_lg = m_last;
    end
    check({tag, " RegWrite"},   64'(bus.RegWrite),   64'(e.e_we));
    check({tag, " WriteReg"},   64'(bus.WriteReg),   64'(e.e_wreg));
    check({tag, " WriteData"},  64'(bus.WriteData),  64'(e.e_wdata));
    check({tag, " last_grant"}, 64'(bus.last_grant), 64'(e.e_lg));
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   w;
    int   prev_w;

    // rst av ar adata         bv br bdata         cv cr c1 c2 | ar br c1b c2b we wr wdata        lg
    // Reset with both requesters valid (and an ignored claim).
    vecs.push_back(mk(1, 1,1,32'h0000_0011,  1,2,32'h0000_0022,  1,7,7,0,  0,0,0,0, 0,0,32'h0,         1));
    vecs.push_back(mk(1, 1,1,32'h0000_0011,  1,2,32'h0000_0022,  1,7,7,0,  0,0,0,0, 0,0,32'h0,         1));
    // Single write from A, then idle.
    vecs.push_back(mk(0, 1,1,32'hAAAA_AAAA,  0,0,32'h0,          0,0,1,0,  1,0,0,0, 1,1,32'hAAAA_AAAA, 0));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,0,0,  0,0,0,0, 0,1,32'hAAAA_AAAA, 0));
    // Fresh reset, then two-cycle contention: A first, B second.
    vecs.push_back(mk(1, 0,0,32'h0,          0,0,32'h0,          0,0,0,0,  0,0,0,0, 0,0,32'h0,         1));
    vecs.push_back(mk(0, 1,2,32'h5555_5555,  1,3,32'h1234_5678,  0,0,0,0,  1,0,0,0, 1,2,32'h5555_5555, 0));
    vecs.push_back(mk(0, 1,2,32'h5555_5555,  1,3,32'h1234_5678,  0,0,0,0,  0,1,0,0, 1,3,32'h1234_5678, 1));
    // Sustained contention, new data after each grant: strict alternation.
    vecs.push_back(mk(0, 1,4,32'h1111_1111,  1,6,32'h6666_6666,  0,0,0,0,  1,0,0,0, 1,4,32'h1111_1111, 0));
    vecs.push_back(mk(0, 1,4,32'h2222_2222,  1,6,32'h6666_6666,  0,0,0,0,  0,1,0,0, 1,6,32'h6666_6666, 1));
    vecs.push_back(mk(0, 1,4,32'h2222_2222,  1,6,32'h7777_7777,  0,0,0,0,  1,0,0,0, 1,4,32'h2222_2222, 0));
    vecs.push_back(mk(0, 1,4,32'h3333_3333,  1,6,32'h7777_7777,  0,0,0,0,  0,1,0,0, 1,6,32'h7777_7777, 1));
    vecs.push_back(mk(0, 1,4,32'h3333_3333,  1,6,32'h8888_8888,  0,0,0,0,  1,0,0,0, 1,4,32'h3333_3333, 0));
    vecs.push_back(mk(0, 1,4,32'h4444_4444,  1,6,32'h8888_8888,  0,0,0,0,  0,1,0,0, 1,6,32'h8888_8888, 1));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,0,0,  0,0,0,0, 0,6,32'h8888_8888, 1));
    // Scoreboard: claim 5, busy until B retires it.
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          1,5,5,0,  0,0,0,0, 0,6,32'h8888_8888, 1));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,5,0,  0,0,1,0, 0,6,32'h8888_8888, 1));
    vecs.push_back(mk(0, 0,0,32'h0,          1,5,32'h0BAD_F00D,  0,0,5,0,  0,1,1,0, 1,5,32'h0BAD_F00D, 1));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,5,0,  0,0,0,0, 0,5,32'h0BAD_F00D, 1));
    // Claim and retire of the same register on one edge: set wins.
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          1,5,5,0,  0,0,0,0, 0,5,32'h0BAD_F00D, 1));
    vecs.push_back(mk(0, 0,0,32'h0,          1,5,32'hCAFE_BABE,  1,5,5,0,  0,1,1,0, 1,5,32'hCAFE_BABE, 1));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,5,0,  0,0,1,0, 0,5,32'hCAFE_BABE, 1));
    // Register 0: handshake completes, no write, claim ignored.
    vecs.push_back(mk(0, 1,0,32'hFFFF_FFFF,  0,0,32'h0,          1,0,5,0,  1,0,1,0, 0,5,32'hCAFE_BABE, 0));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,5,0,  0,0,1,0, 0,5,32'hCAFE_BABE, 0));
    // Claim of one register and retire of another on the same edge.
    vecs.push_back(mk(0, 1,5,32'h0000_0005,  0,0,32'h0,          1,9,5,9,  1,0,1,0, 1,5,32'h0000_0005, 0));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,5,9,  0,0,0,1, 0,5,32'h0000_0005, 0));
    // Reset right behind a transfer: pending write squashed, busy cleared.
    vecs.push_back(mk(0, 1,7,32'h7777_0000,  0,0,32'h0,          0,0,9,5,  1,0,1,0, 1,7,32'h7777_0000, 0));
    vecs.push_back(mk(1, 0,0,32'h0,          1,9,32'h0000_0001,  1,10,9,10, 0,0,1,0, 0,0,32'h0,        1));
    vecs.push_back(mk(0, 0,0,32'h0,          0,0,32'h0,          0,0,9,10, 0,0,0,0, 0,0,32'h0,         1));

    // Initial reset so the scoreboard is defined before the first lookup.
    v = mk(1, 0,0,32'h0, 0,0,32'h0, 0,0,0,0, 0,0,0,0, 0,0,32'h0, 1);
    drive(v);
    @(posedge clk);
    m_edge(0);
    #1;

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i]);
      do_cycle($sformatf("vec%0d", i), 1'b0, vecs[i], w);
    end

    // Randomized run against the model. A requester that was valid but not
    // granted keeps its register and data stable.
    prev_w = 0;
    v = mk(0, 0,0,32'h0, 0,0,32'h0, 0,0,0,0, 0,0,0,0, 0,0,32'h0, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      v.rst = ($urandom_range(0, 39) == 0);
      if (!(v.av && prev_w != 1)) begin
        v.av    = ($urandom_range(0, 9) < 6);
        v.areg  = ADDR_W'($urandom_range(0, 7));
        v.adata = $urandom;
      end
      if (!(v.bv && prev_w != 2)) begin
        v.bv    = ($urandom_range(0, 9) < 6);
        v.breg  = ADDR_W'($urandom_range(0, 7));
        v.bdata = $urandom;
      end
      v.cv   = ($urandom_range(0, 9) < 3);
      v.creg = ADDR_W'($urandom_range(0, 7));
      v.c1   = ADDR_W'($urandom_range(0, 7));
      v.c2   = ADDR_W'($urandom_range(0, 7));
      drive(v);
      do_cycle($sformatf("rnd%0d", cyc), 1'b1, v, w);
      prev_w = w;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
